// File: rtl/sopc_sysid_ext.sv
// System ID peripheral: ID/timestamp/info/user words, scratch, uptime.
// Define SYSID_UPTIME_EN to build the 64-bit uptime counter and hi shadow.
module sopc_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [15:0] VERSION   = 16'h0001,
  parameter int          NUM_USER  = 2,
  parameter int          ADDR_W    = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic [3:0]          byteenable,
  input  logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] user_id,
  output logic [31:0]         readdata,
  output logic                readdatavalid
);

  localparam logic [ADDR_W-1:0] A_SYSID = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_INFO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SCR   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_LO    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_HI    = ADDR_W'(5);

  if (6 + NUM_USER > (1 << ADDR_W)) begin : g_map_chk
    $error("sopc_sysid_ext: NUM_USER does not fit in address map");
  end

  logic [31:0] scratch;
  logic [31:0] uptime_lo;
  logic [31:0] uptime_hi;
  logic [31:0] rd_mux;
  logic        up_en;

`ifdef SYSID_UPTIME_EN
  logic [63:0] count;
  logic [31:0] hi_shadow;

  // A clear wins over the increment; the shadow tracks the pre-clear value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count     <= '0;
      hi_shadow <= '0;
    end else begin
      if (write && address == A_LO)
        count <= '0;
      else
        count <= count + 64'd1;
      if (read && address == A_LO)
        hi_shadow <= count[63:32];
    end
  end

  assign uptime_lo = count[31:0];
  assign uptime_hi = hi_shadow;
  assign up_en     = 1'b1;
`else
  assign uptime_lo = '0;
  assign uptime_hi = '0;
  assign up_en     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (write && address == A_SCR) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b])
          scratch[8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_SYSID: rd_mux = SYSTEM_ID;
      A_TS:    rd_mux = TIMESTAMP;
      A_INFO:  rd_mux = {VERSION, 8'(NUM_USER), 7'd0, up_en};
      A_SCR:   rd_mux = scratch;
      A_LO:    rd_mux = uptime_lo;
      A_HI:    rd_mux = uptime_hi;
      default: rd_mux = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++)
      if (address == ADDR_W'(6 + k))
        rd_mux = user_id[k*32 +: 32];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read)
        readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sopc_sysid_ext.sv
// Scoreboard bench for sopc_sysid_ext against a behavioural register model.
// Uptime checks are built only when SYSID_UPTIME_EN is defined.
module tb_sopc_sysid_ext;

  localparam logic [31:0] SID = 32'h5F95_AE8A;
  localparam logic [31:0] TS  = 32'h00AA_0000;
  localparam logic [15:0] VER = 16'h0002;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [63:0] user_id = {32'hCAFE_0001, 32'h0000_BEEF};
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [31:0] rd1;
  logic        rv1;

  sopc_sysid_ext #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .VERSION(VER),
    .NUM_USER(2), .ADDR_W(3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .user_id(user_id),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  sopc_sysid_ext #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .VERSION(VER),
    .NUM_USER(1), .ADDR_W(3)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .user_id(user_id[31:0]),
    .readdata(rd1), .readdatavalid(rv1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Register model: scratch word, hi shadow, and the count expressed as
  // a reference value plus elapsed edges.
  logic [31:0] m_scr = '0;
  logic [31:0] m_sh  = '0;
  logic [63:0] ref_val = '0;
  int          ref_edge = 0;

  function automatic logic [63:0] cnt_at(int e);
    return ref_val + 64'(e - ref_edge);
  endfunction

  function automatic logic [31:0] exp_rd(logic [2:0] a, int e);
    logic [63:0] c;
    c = cnt_at(e);
    case (a)
      3'd0: return SID;
      3'd1: return TS;
      3'd2: return {VER, 8'd2, 7'd0, UP};
      3'd3: return m_scr;
      3'd4: return UP ? c[31:0] : 32'd0;
      3'd5: return UP ? m_sh : 32'd0;
      3'd6: return user_id[31:0];
      default: return user_id[63:32];
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (readdatavalid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_rdv: pulse at edge %0d, required none",
                 cyc);
      end else begin
        x = q.pop_front();
        if (x.edge_n != cyc || readdata !== x.data) begin
          n_fail++;
          $display("FAIL %s: got %h at edge %0d, required %h at edge %0d",
                   x.name, readdata, cyc, x.data, x.edge_n);
        end
      end
    end
  end

  task automatic op(bit rd, bit wr, logic [2:0] a,
                    logic [31:0] wd, logic [3:0] be, string nm);
    int e;
    logic [63:0] c;
    @(negedge clock);
    read = rd; write = wr; address = a;
    writedata = wd; byteenable = be;
    e = cyc + 1;
    if (rd) q.push_back('{e, exp_rd(a, e), nm});
    if (rd && a == 3'd4 && UP) begin
      c = cnt_at(e);
      m_sh = c[63:32];
    end
    if (wr && a == 3'd3)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
    if (wr && a == 3'd4 && UP) begin
      ref_edge = e + 1;
      ref_val  = '0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) op(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, "idle");
  endtask

  task automatic do_reset(bit rd_too);
    int e;
    @(negedge clock);
    reset_n = 1'b0; read = rd_too; write = 1'b0; address = 3'd3;
    e = cyc + 1;
    m_scr = '0; m_sh = '0;
    ref_edge = e + 1; ref_val = '0;
    @(negedge clock);
    reset_n = 1'b1; read = 1'b0;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_rdv", {31'd0, readdatavalid}, 32'd0);
  endtask

`ifdef SYSID_UPTIME_EN
  task automatic set_count(logic [63:0] v);
    int e;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    force dut.count = v;
    e = cyc + 1;
    @(negedge clock);
    release dut.count;
    ref_edge = e + 1;
    ref_val  = v;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b0);
    op(1, 0, 3'd0, 0, 0, "sysid");
    op(1, 0, 3'd1, 0, 0, "timestamp");
    op(1, 0, 3'd2, 0, 0, "info");

    op(0, 1, 3'd3, 32'hDEAD_BEEF, 4'b1111, "w");
    op(0, 1, 3'd3, 32'h1234_5678, 4'b0101, "w");
    op(1, 0, 3'd3, 0, 0, "scratch_mask");
    do_reset(1'b1);
    op(1, 0, 3'd3, 0, 0, "scratch_after_reset");
    op(1, 1, 3'd3, 32'hA5A5_A5A5, 4'b1111, "scratch_rw_same");
    op(1, 0, 3'd3, 0, 0, "scratch_rw_next");
    op(0, 1, 3'd0, 32'hFFFF_FFFF, 4'b1111, "w_ro");
    op(0, 1, 3'd5, 32'hFFFF_FFFF, 4'b1111, "w_ro");
    op(1, 0, 3'd0, 0, 0, "sysid_after_ro_write");
    op(1, 0, 3'd5, 0, 0, "hi_after_ro_write");

    op(1, 0, 3'd6, 0, 0, "user0");
    op(1, 0, 3'd7, 0, 0, "user1");
    @(negedge clock);
    read = 1'b0;
    chk("nu1_addr7_data", rd1, 32'd0);
    chk("nu1_addr7_rdv", {31'd0, rv1}, 32'd1);

`ifdef SYSID_UPTIME_EN
    set_count(64'h0000_0001_FFFF_FFFE);
    op(1, 0, 3'd4, 0, 0, "lo_pre_carry");
    op(1, 0, 3'd4, 0, 0, "lo_carry");
    op(1, 0, 3'd5, 0, 0, "hi_carry");
    idle(3);
    op(1, 0, 3'd5, 0, 0, "hi_no_lo");
    op(0, 1, 3'd4, $urandom, 4'b1111, "clear");
    idle(4);
    op(1, 0, 3'd4, 0, 0, "lo_after_clear");
    op(1, 0, 3'd5, 0, 0, "hi_after_clear");
    set_count(64'hFFFF_FFFF_FFFF_FFFE);
    op(1, 0, 3'd4, 0, 0, "lo_all_ones");
    op(1, 0, 3'd5, 0, 0, "hi_all_ones");
    op(1, 0, 3'd4, 0, 0, "lo_wrapped");
    op(1, 0, 3'd5, 0, 0, "hi_wrapped");
    op(1, 1, 3'd4, 32'h0, 4'b0000, "lo_rw_same");
    op(1, 0, 3'd4, 0, 0, "lo_rw_next");
`endif

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle(1);
        user_id = {$urandom, $urandom};
      end
      op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
         3'($urandom_range(0, 7)), $urandom, 4'($urandom),
         "random");
      if ($urandom_range(0, 40) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    idle(3);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
